// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller between the board keys and the HEX4/HEX5 decoders.
// Conditions the two active-low keys, runs the start/pause/lap/clear FSM,
// gates the 1 s prescaler and owns the two-digit packed-BCD seconds count.
module stopwatch_ctrl #(
    parameter int unsigned TIMING      = 1000000,
    parameter int unsigned DB_CYCLES   = 50000,
    parameter logic [7:0]  MAX_BCD     = 8'h99,
    parameter bit          STOP_AT_MAX = 1'b1
) (
    input  logic       ADC_CLK_10,
    input  logic       reset,
    input  logic [1:0] key_n,
    output logic [7:0] count_bcd,
    output logic [7:0] disp_bcd,
    output logic       sec_tick,
    output logic       led,
    output logic       running,
    output logic       done,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        LAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int unsigned PRE_W = (TIMING > 1) ? $clog2(TIMING) : 1;
    localparam int unsigned DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TIMING - 1);
    localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(TIMING / 2);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

    // Key conditioning: index 0 = start/stop, index 1 = lap/clear.
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      key_lvl_q;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [1:0]      press_q;

    // Controller state.
    state_t           state_q;
    state_t           state_d;
    logic [PRE_W-1:0] pre_cnt_q;
    logic [PRE_W-1:0] pre_cnt_d;
    logic [7:0]       count_d;
    logic [7:0]       disp_d;
    logic             max_hit;

    logic start_ev;
    logic lap_ev;

    assign start_ev = press_q[0];
    assign lap_ev   = press_q[1];

    // Packed-BCD increment; 99 rolls over to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] ones;
        logic [3:0] tens;
        ones = v[3:0];
        tens = v[7:4];
        if (ones == 4'd9) begin
            ones = 4'd0;
            tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

    // Synchronize each key, then accept a level only after DB_CYCLES agreeing samples.
    always_ff @(posedge ADC_CLK_10) begin
        // NOTE: flops use non-blocking assignments so every register samples
        // the pre-edge value of its neighbours regardless of statement order.
        if (reset) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            key_lvl_q <= 2'b11;
            press_q   <= 2'b00;
            // NOTE: this small counter array is control state, not storage,
            // so every entry is reset; a RAM-style array would be left alone.
            for (int k = 0; k < 2; k++) begin
                db_cnt_q[k] <= '0;
            end
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            for (int k = 0; k < 2; k++) begin
                press_q[k] <= 1'b0;
                if (sync2_q[k] != key_lvl_q[k]) begin
                    if (db_cnt_q[k] == DB_LAST) begin
                        key_lvl_q[k] <= sync2_q[k];
                        db_cnt_q[k]  <= '0;
                        // Only a newly accepted low level is a press.
                        press_q[k]   <= ~sync2_q[k];
                    end else begin
                        db_cnt_q[k] <= db_cnt_q[k] + DB_W'(1);
                    end
                end else begin
                    db_cnt_q[k] <= '0;
                end
            end
        end
    end

    // Next-state, prescaler and count logic; events outrank the terminal-count stop.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        count_d   = count_bcd;
        sec_tick  = 1'b0;
        max_hit   = 1'b0;

        case (state_q)
            IDLE: begin
                pre_cnt_d = '0;
                if (start_ev) begin
                    state_d = RUN;
                end
            end
            RUN, LAP: begin
                sec_tick  = (pre_cnt_q == PRE_LAST);
                pre_cnt_d = sec_tick ? '0 : pre_cnt_q + PRE_W'(1);
                if (sec_tick) begin
                    if (count_bcd == MAX_BCD) begin
                        if (STOP_AT_MAX) begin
                            max_hit = 1'b1;
                        end else begin
                            count_d = 8'h00;
                        end
                    end else begin
                        count_d = bcd_inc(count_bcd);
                    end
                end
                // Start wins over a simultaneous lap.
                if (start_ev) begin
                    state_d = PAUSE;
                end else if (lap_ev) begin
                    state_d = (state_q == RUN) ? LAP : RUN;
                end else if (max_hit) begin
                    state_d = DONE;
                end
            end
            PAUSE: begin
                if (start_ev) begin
                    state_d = RUN;
                end else if (lap_ev) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                pre_cnt_d = '0;
                if (start_ev || lap_ev) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // IDLE always means a cleared stopwatch, whatever the way in.
        if (state_d == IDLE) begin
            count_d   = 8'h00;
            pre_cnt_d = '0;
        end

        // Entering LAP freezes the current count; otherwise track count exactly.
        if (state_d == LAP) begin
            disp_d = (state_q == LAP) ? disp_bcd : count_bcd;
        end else begin
            disp_d = count_d;
        end
    end

    // Controller registers.
    always_ff @(posedge ADC_CLK_10) begin
        if (reset) begin
            state_q   <= IDLE;
            pre_cnt_q <= '0;
            count_bcd <= 8'h00;
            disp_bcd  <= 8'h00;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            count_bcd <= count_d;
            disp_bcd  <= disp_d;
        end
    end

    assign running = (state_q == RUN) || (state_q == LAP);
    assign done    = (state_q == DONE);
    assign led     = running && (pre_cnt_q < PRE_HALF);
    assign state   = state_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Button-driven controller that sequences the seconds timebase and the two-digit BCD seconds counter feeding HEX4/HEX5 and the LEDR[0] heartbeat. It conditions the raw active-low KEY inputs and runs a start/pause/lap/clear state machine. It gates the 1 s prescaler, owns the BCD count and presents a display value that can be frozen for lap capture. It sits between the board pins and the sevenSeg decoders in the top level.

Parameters:
TIMING, 1000000, ADC_CLK_10 cycles per count tick (1 s at 10 MHz); legal range 2..2^24-1.
DB_CYCLES, 50000, consecutive identical synchronized samples needed to accept a key level change (5 ms).
MAX_BCD, 8'h99, terminal count in packed BCD; both nibbles must be 0-9.
STOP_AT_MAX, 1, 1 = enter DONE at MAX_BCD; 0 = wrap to 8'h00 and keep running.

Ports:
ADC_CLK_10  in  1  system clock, all logic on its rising edge
reset  in  1  synchronous, active-high reset
key_n  in  2  raw asynchronous buttons, active low; [0] = start/stop, [1] = lap/clear
count_bcd  out  8  live BCD count {tens, ones}
disp_bcd  out  8  value for the sevenSeg decoders (frozen while in LAP)
sec_tick  out  1  one-cycle pulse on each count increment
led  out  1  heartbeat, for LEDR[0]
running  out  1  high in RUN or LAP
done  out  1  high in DONE
state  out  3  IDLE=0, RUN=1, PAUSE=2, LAP=3, DONE=4

Behaviour:
- Reset (sampled at clock edge): state=IDLE; count_bcd=disp_bcd=0; prescaler=0; sec_tick=led=running=done=0. Synchronizers and accepted key levels reset to released (1). Debounce counters reset to 0.
- Key conditioning, per key: 2-flop synchronizer, then debounce counter. The accepted level changes when DB_CYCLES consecutive synchronized samples differ from it.
- Press event: one-cycle pulse on an accepted 1->0 change. If key_n goes low before edge N and stays low, the event is high in the cycle after edge N+1+DB_CYCLES. Releases generate no event. Glitches shorter than DB_CYCLES cycles generate no event.
- A key held low through reset produces exactly one press event, DB_CYCLES+2 cycles after reset deasserts.
- Simultaneous start and lap events in one cycle: start is acted on, lap is discarded.
- Prescaler pre_cnt, 0..TIMING-1:
  - increments in RUN/LAP; at TIMING-1 it wraps to 0 and sec_tick pulses that cycle;
  - holds its value in PAUSE; cleared in IDLE and DONE.
- led = 1 while running and pre_cnt < TIMING/2; otherwise 0.
- Count update on sec_tick:
  - ones nibble 9 -> 0 with carry into tens; otherwise ones+1;
  - if count_bcd == MAX_BCD: STOP_AT_MAX=1 -> count holds, state -> DONE; STOP_AT_MAX=0 -> count -> 8'h00.
- State transitions, evaluated on events:
  - IDLE: start -> RUN (pre_cnt starts from 0); lap is ignored.
  - RUN: start -> PAUSE; lap -> LAP, snapshotting count_bcd into disp_bcd.
  - LAP: count keeps running and disp_bcd holds the snapshot. Lap -> RUN, disp resumes tracking. Start -> PAUSE, disp resumes tracking.
  - PAUSE: start -> RUN (prescaler resumes from its held value); lap -> IDLE (count and prescaler cleared).
  - DONE: start or lap -> IDLE.
- The DONE entry edge and the MAX tick are the same cycle. An event arriving in that cycle is evaluated against the old state (RUN/LAP).
- disp_bcd: registered, updated in the same cycle as count_bcd in every state except LAP. No extra latency versus count_bcd.
- Outputs never go X after reset. state encodings 5-7 are unreachable; if entered they return to IDLE on the next cycle.

Test Plan:
All scenarios use TIMING=10, DB_CYCLES=4.
1. Reset, press key_n[0] for 8 cycles -> press event 6 cycles after the low edge; state 0->1. First sec_tick 10 cycles later; count_bcd=8'h01; led high for 5 of every 10 cycles.
2. Run to 8'h09, then one more tick -> count_bcd=8'h10. With STOP_AT_MAX=1 and MAX_BCD=8'h12: at 8'h12 state=4, done=1, no further ticks. With STOP_AT_MAX=0: 8'h99 -> 8'h00, still RUN.
3. RUN at 8'h03, press lap -> state=3, disp_bcd stays 8'h03 while count_bcd reaches 8'h06. Press lap -> disp_bcd=8'h06 in the same cycle it is observed.
4. Pause with pre_cnt=7 and count 8'h04; wait 50 cycles -> no tick, count still 8'h04. Start -> next tick after exactly 3 cycles. Pause, then lap -> state=0, count=8'h00.
5. 3-cycle low glitch on key_n[1] -> no event. Both keys pressed in the same cycle while in RUN -> PAUSE, never LAP.
6. Assert reset mid-RUN with count 8'h57 and key_n[0] held low -> all outputs zero. Exactly one start event 6 cycles after reset deasserts -> RUN.
